// File: rtl/sat_engine_lanes.sv
// DPLL SAT engine: LANES clause rows are checked per cycle against the live assignment,
// with unit propagation, lowest-index decisions and chronological backtracking.
// Define SAT_ENGINE_STATS_EN to build the decision_count / cycle_count counters.
module sat_engine_lanes #(
  parameter int NUM_ROWS     = 32,
  parameter int COLS_PER_ROW = 4,
  parameter int NUM_VARS     = 16,
  parameter int LIT_WIDTH    = 6,
  parameter int LANES        = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load_we,
  input  logic [$clog2(NUM_ROWS)-1:0]         load_addr,
  input  logic [COLS_PER_ROW*LIT_WIDTH-1:0]   load_data,
  input  logic                                start,
  input  logic                                polarity_mode,
  input  logic [15:0]                         conflict_limit,
  output logic                                done,
  output logic [1:0]                          result,
  output logic [NUM_VARS:1]                   assigned,
  output logic [NUM_VARS:1]                   values,
  output logic [15:0]                         conflict_count,
  output logic [15:0]                         decision_count,
  output logic [31:0]                         cycle_count,
  output logic [2:0]                          state_out
);

  localparam int AW    = $clog2(NUM_ROWS);
  localparam int ROW_W = COLS_PER_ROW * LIT_WIDTH;
  localparam int VW    = LIT_WIDTH - 1;
  localparam int VSPAN = 2 ** VW;
  localparam int IW    = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int PW    = $clog2(NUM_VARS + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_DECIDE    = 3'd2,
    S_BACKTRACK = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_SAT   = 2'd1;
  localparam logic [1:0] RES_UNSAT = 2'd2;
  localparam logic [1:0] RES_ABORT = 2'd3;

  state_e               state_q, state_d;
  logic [AW-1:0]        row_base_q, row_base_d;
  logic                 changed_q, changed_d;
  logic [NUM_VARS:1]    assigned_q, assigned_d;
  logic [NUM_VARS:1]    values_q, values_d;
  logic [PW-1:0]        trail_ptr_q, trail_ptr_d;
  logic [15:0]          conflict_count_q, conflict_count_d;
  logic                 done_q, done_d;
  logic [1:0]           result_q, result_d;
  logic                 polarity_q, polarity_d;
  logic [15:0]          limit_q, limit_d;

  logic [VW-1:0]        trail_var_q [NUM_VARS];
  logic [NUM_VARS-1:0]  trail_forced_q;
  logic                 tr_we;
  logic [IW-1:0]        tr_idx;
  logic [VW-1:0]        tr_var;
  logic                 tr_forced;

  logic                 var_we;
  logic [VW-1:0]        var_sel;
  logic                 var_asg;
  logic                 var_val;

  logic                 load_ok;
  logic                 start_ok;
  logic                 last_group;

  assign load_ok    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok   = start && load_ok;
  assign last_group = (row_base_q == AW'(NUM_ROWS - LANES));

  logic [ROW_W-1:0] clause_mem [NUM_ROWS];

  always_ff @(posedge clk) begin
    if (load_we && load_ok) begin
      clause_mem[load_addr] <= load_data;
    end
  end

  // Bit 0 and indices above NUM_VARS stay zero so any literal field can index directly.
  logic [VSPAN-1:0] asg_ext;
  logic [VSPAN-1:0] val_ext;
  assign asg_ext = VSPAN'({assigned_q, 1'b0});
  assign val_ext = VSPAN'({values_q, 1'b0});

  logic [LANES-1:0] lane_conflict;
  logic [LANES-1:0] lane_unit;
  logic [LANES-1:0] lane_unit_pol;
  logic [VW-1:0]    lane_unit_var [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ROW_W-1:0]        row;
    logic [COLS_PER_ROW-1:0] col_live;
    logic [COLS_PER_ROW-1:0] col_true;
    logic [COLS_PER_ROW-1:0] col_open;
    logic [COLS_PER_ROW-1:0] col_pol;
    logic [VW-1:0]           col_var [COLS_PER_ROW];
    logic [VW-1:0]           unit_var;
    logic                    unit_pol;

    assign row = clause_mem[row_base_q + AW'(gi)];

    for (genvar gc = 0; gc < COLS_PER_ROW; gc++) begin : g_col
      logic [LIT_WIDTH-1:0] lit;
      assign lit          = row[gc*LIT_WIDTH +: LIT_WIDTH];
      assign col_var[gc]  = lit[LIT_WIDTH-1:1];
      assign col_pol[gc]  = lit[0];
      // Out-of-range variable numbers are treated like empty slots.
      assign col_live[gc] = (col_var[gc] != '0) && (col_var[gc] <= VW'(NUM_VARS));
      assign col_open[gc] = col_live[gc] && !asg_ext[col_var[gc]];
      assign col_true[gc] = col_live[gc] && asg_ext[col_var[gc]]
                            && (val_ext[col_var[gc]] == col_pol[gc]);
    end

    always_comb begin
      unit_var = '0;
      unit_pol = 1'b0;
      for (int c = 0; c < COLS_PER_ROW; c++) begin
        if (col_open[c]) begin
          unit_var = col_var[c];
          unit_pol = col_pol[c];
        end
      end
    end

    assign lane_conflict[gi] = (|col_live) && !(|col_true) && !(|col_open);
    assign lane_unit[gi]     = !(|col_true) && ($countones(col_open) == 1);
    assign lane_unit_var[gi] = unit_var;
    assign lane_unit_pol[gi] = unit_pol;
  end

  logic          sel_found;
  logic [VW-1:0] sel_var;
  logic          sel_pol;

  always_comb begin
    sel_found = 1'b0;
    sel_var   = '0;
    sel_pol   = 1'b0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_unit[l]) begin
        sel_found = 1'b1;
        sel_var   = lane_unit_var[l];
        sel_pol   = lane_unit_pol[l];
      end
    end
  end

  logic          dec_found;
  logic [VW-1:0] dec_var;

  always_comb begin
    dec_found = 1'b0;
    dec_var   = '0;
    for (int k = NUM_VARS; k >= 1; k--) begin
      if (!assigned_q[k]) begin
        dec_found = 1'b1;
        dec_var   = VW'(k);
      end
    end
  end

  logic [IW-1:0] top_idx;
  logic [VW-1:0] top_var;
  logic          top_forced;

  assign top_idx    = IW'(trail_ptr_q - PW'(1));
  assign top_var    = trail_var_q[top_idx];
  assign top_forced = trail_forced_q[top_idx];

  always_comb begin
    state_d          = state_q;
    row_base_d       = row_base_q;
    changed_d        = changed_q;
    assigned_d       = assigned_q;
    values_d         = values_q;
    trail_ptr_d      = trail_ptr_q;
    conflict_count_d = conflict_count_q;
    done_d           = done_q;
    result_d         = result_q;
    polarity_d       = polarity_q;
    limit_d          = limit_q;
    var_we           = 1'b0;
    var_sel          = '0;
    var_asg          = 1'b0;
    var_val          = 1'b0;
    tr_we            = 1'b0;
    tr_idx           = IW'(trail_ptr_q);
    tr_var           = '0;
    tr_forced        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          assigned_d       = '0;
          values_d         = '0;
          trail_ptr_d      = '0;
          conflict_count_d = '0;
          done_d           = 1'b0;
          result_d         = RES_NONE;
          polarity_d       = polarity_mode;
          limit_d          = conflict_limit;
          row_base_d       = '0;
          changed_d        = 1'b0;
          state_d          = S_SCAN;
        end
      end

      S_SCAN: begin
        if (|lane_conflict) begin
          conflict_count_d = conflict_count_q + 16'd1;
          row_base_d       = '0;
          changed_d        = 1'b0;
          state_d          = S_BACKTRACK;
        end else begin
          if (sel_found) begin
            var_we      = 1'b1;
            var_sel     = sel_var;
            var_asg     = 1'b1;
            var_val     = sel_pol;
            tr_we       = 1'b1;
            tr_var      = sel_var;
            tr_forced   = 1'b1;
            trail_ptr_d = trail_ptr_q + PW'(1);
          end
          // A unit found in the final group still counts as a change for this pass.
          if (last_group) begin
            row_base_d = '0;
            changed_d  = 1'b0;
            if (!(changed_q || sel_found)) begin
              state_d = S_DECIDE;
            end
          end else begin
            row_base_d = row_base_q + AW'(LANES);
            changed_d  = changed_q | sel_found;
          end
        end
      end

      S_DECIDE: begin
        if (dec_found) begin
          var_we      = 1'b1;
          var_sel     = dec_var;
          var_asg     = 1'b1;
          var_val     = polarity_q;
          tr_we       = 1'b1;
          tr_var      = dec_var;
          tr_forced   = 1'b0;
          trail_ptr_d = trail_ptr_q + PW'(1);
          row_base_d  = '0;
          changed_d   = 1'b0;
          state_d     = S_SCAN;
        end else begin
          done_d   = 1'b1;
          result_d = RES_SAT;
          state_d  = S_DONE;
        end
      end

      S_BACKTRACK: begin
        if ((limit_q != 16'd0) && (conflict_count_q == limit_q)) begin
          done_d   = 1'b1;
          result_d = RES_ABORT;
          state_d  = S_DONE;
        end else if (trail_ptr_q == '0) begin
          done_d   = 1'b1;
          result_d = RES_UNSAT;
          state_d  = S_DONE;
        end else if (top_forced) begin
          var_we      = 1'b1;
          var_sel     = top_var;
          var_asg     = 1'b0;
          var_val     = 1'b0;
          trail_ptr_d = trail_ptr_q - PW'(1);
        end else begin
          // Flip the most recent decision in place; it becomes a forced entry.
          var_we     = 1'b1;
          var_sel    = top_var;
          var_asg    = 1'b1;
          var_val    = ~val_ext[top_var];
          tr_we      = 1'b1;
          tr_idx     = top_idx;
          tr_var     = top_var;
          tr_forced  = 1'b1;
          row_base_d = '0;
          changed_d  = 1'b0;
          state_d    = S_SCAN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (var_we) begin
      for (int k = 1; k <= NUM_VARS; k++) begin
        if (var_sel == VW'(k)) begin
          assigned_d[k] = var_asg;
          values_d[k]   = var_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      row_base_q       <= '0;
      changed_q        <= 1'b0;
      assigned_q       <= '0;
      values_q         <= '0;
      trail_ptr_q      <= '0;
      conflict_count_q <= '0;
      done_q           <= 1'b0;
      result_q         <= RES_NONE;
      polarity_q       <= 1'b0;
      limit_q          <= '0;
    end else begin
      state_q          <= state_d;
      row_base_q       <= row_base_d;
      changed_q        <= changed_d;
      assigned_q       <= assigned_d;
      values_q         <= values_d;
      trail_ptr_q      <= trail_ptr_d;
      conflict_count_q <= conflict_count_d;
      done_q           <= done_d;
      result_q         <= result_d;
      polarity_q       <= polarity_d;
      limit_q          <= limit_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        trail_var_q[i] <= '0;
      end
      trail_forced_q <= '0;
    end else if (tr_we) begin
      trail_var_q[tr_idx]    <= tr_var;
      trail_forced_q[tr_idx] <= tr_forced;
    end
  end

`ifdef SAT_ENGINE_STATS_EN
  logic [15:0] decision_count_q;
  logic [31:0] cycle_count_q;
  logic        solving;

  assign solving = (state_q == S_SCAN) || (state_q == S_DECIDE) || (state_q == S_BACKTRACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decision_count_q <= '0;
      cycle_count_q    <= '0;
    end else if (start_ok) begin
      decision_count_q <= '0;
      cycle_count_q    <= '0;
    end else begin
      if (solving) begin
        cycle_count_q <= cycle_count_q + 32'd1;
      end
      if ((state_q == S_DECIDE) && dec_found) begin
        decision_count_q <= decision_count_q + 16'd1;
      end
    end
  end

  assign decision_count = decision_count_q;
  assign cycle_count    = cycle_count_q;
`else
  assign decision_count = '0;
  assign cycle_count    = '0;
`endif

  assign done           = done_q;
  assign result         = result_q;
  assign assigned       = assigned_q;
  assign values         = values_q;
  assign conflict_count = conflict_count_q;
  assign state_out      = state_q;

endmodule
